// File: rtl/tbird_pkg.sv
// Shared types and default timing for the T-bird input conditioner.
package tbird_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEFT,
    RIGHT,
    HAZ,
    FAULT
  } tbird_in_state_e;

  localparam int unsigned TBIRD_DB_CYCLES   = 4;
  localparam int unsigned TBIRD_LANE_CYCLES = 12;

endpackage

// File: rtl/tbird_debounce.sv
// Two-flop synchroniser followed by a stability-counter debouncer for one raw contact.
module tbird_debounce
  import tbird_pkg::*;
#(
  parameter int unsigned DB_CYCLES = TBIRD_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_b,
  input  logic raw,
  output logic db
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      // A reversion to the debounced value restarts the stability count
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign db = r_db;

endmodule

// File: rtl/tbird_input_cond.sv
// Debounced, conflict-resolved left/right/hazard requests for tbird_fsm.
// Optional lane-change stretch enabled by defining TBIRD_LANE_CHANGE_EN.
module tbird_input_cond
  import tbird_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = TBIRD_DB_CYCLES,
  parameter int unsigned LANE_CYCLES = TBIRD_LANE_CYCLES
) (
  input  logic clk,
  input  logic rst_b,
  input  logic left_raw,
  input  logic right_raw,
  input  logic haz_btn_raw,
  output logic left,
  output logic right,
  output logic haz,
  output logic fault
);

  logic w_db_left;
  logic w_db_right;
  logic w_db_haz;
  logic r_haz_db_q;
  logic r_haz_latch;

  tbird_in_state_e r_state;
  tbird_in_state_e w_target;
  tbird_in_state_e w_next;

  logic r_left;
  logic r_right;
  logic r_haz;
  logic r_fault;

`ifdef TBIRD_LANE_CHANGE_EN
  localparam int unsigned LANE_W = $clog2(LANE_CYCLES + 1);
  localparam logic [LANE_W-1:0] LANE_LOAD = LANE_W'(LANE_CYCLES - 1);
  logic [LANE_W-1:0] r_stretch;
`endif

  tbird_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .clk   (clk),
    .rst_b (rst_b),
    .raw   (left_raw),
    .db    (w_db_left)
  );

  tbird_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .clk   (clk),
    .rst_b (rst_b),
    .raw   (right_raw),
    .db    (w_db_right)
  );

  tbird_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_haz (
    .clk   (clk),
    .rst_b (rst_b),
    .raw   (haz_btn_raw),
    .db    (w_db_haz)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_haz_db_q  <= 1'b0;
      r_haz_latch <= 1'b0;
    end else begin
      r_haz_db_q <= w_db_haz;
      if (w_db_haz && !r_haz_db_q) begin
        r_haz_latch <= ~r_haz_latch;
      end
    end
  end

  always_comb begin
    w_target = IDLE;
    if (r_haz_latch) begin
      w_target = HAZ;
    end else if (w_db_left && w_db_right) begin
      w_target = FAULT;
    end else if (w_db_left) begin
      w_target = LEFT;
    end else if (w_db_right) begin
      w_target = RIGHT;
    end
`ifdef TBIRD_LANE_CHANGE_EN
    // Stretch only replaces a drop to IDLE; any real request overrides it
    if ((w_target == IDLE) && ((r_state == LEFT) || (r_state == RIGHT)) && (r_stretch != '0)) begin
      w_target = r_state;
    end
`endif
    w_next = w_target;
    // Changing between two active requests inserts one IDLE cycle
    if ((r_state != IDLE) && (w_target != IDLE) && (w_target != r_state)) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_haz   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_left  <= (w_next == LEFT);
      r_right <= (w_next == RIGHT);
      r_haz   <= (w_next == HAZ) || (w_next == FAULT);
      r_fault <= (w_next == FAULT);
    end
  end

`ifdef TBIRD_LANE_CHANGE_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_stretch <= '0;
    end else if ((w_next == LEFT) || (w_next == RIGHT)) begin
      if (w_next != r_state) begin
        r_stretch <= LANE_LOAD;
      end else if (r_stretch != '0) begin
        r_stretch <= r_stretch - 1'b1;
      end
    end else begin
      r_stretch <= '0;
    end
  end
`else
  // LANE_CYCLES stays in the parameter list so both builds share one interface
  if (LANE_CYCLES == 0) begin : g_lane_unused
  end
`endif

  assign left  = r_left;
  assign right = r_right;
  assign haz   = r_haz;
  assign fault = r_fault;

endmodule

// File: tb/tb_tbird_input_cond.sv
// Directed self-checking bench for tbird_input_cond (DB_CYCLES=4, LANE_CYCLES=12, 10 ns clock).
module tb_tbird_input_cond;

  logic clk = 1'b0;
  logic rst_b;
  logic left_raw;
  logic right_raw;
  logic haz_btn_raw;
  logic left;
  logic right;
  logic haz;
  logic fault;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  tbird_input_cond #(
    .DB_CYCLES   (4),
    .LANE_CYCLES (12)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .left_raw    (left_raw),
    .right_raw   (right_raw),
    .haz_btn_raw (haz_btn_raw),
    .left        (left),
    .right       (right),
    .haz         (haz),
    .fault       (fault)
  );

  // {left, right, haz, fault}
  function automatic logic [7:0] outs();
    return {4'b0000, left, right, haz, fault};
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    logic [5:0]  pat;
    int unsigned cnt;
    int unsigned first;

    rst_b       = 1'b0;
    left_raw    = 1'b1;
    right_raw   = 1'b0;
    haz_btn_raw = 1'b0;

    // 1. reset hold with left asserted, then 7-edge latency
    tick(1);
    check_eq("rst_hold0", outs(), 8'b0000);
    tick(1);
    check_eq("rst_hold1", outs(), 8'b0000);
    #4 rst_b = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (i == 6) check_eq("rst_lat_e6", outs(), 8'b0000);
    end
    check_eq("rst_lat_e7", outs(), 8'b1000);

    // 2. bounce shorter than the debounce window
    left_raw = 1'b0;
    tick(10);
    check_eq("bounce_idle", outs(), 8'b0000);
    pat = 6'b110110;
    for (int i = 0; i < 6; i++) begin
      left_raw = pat[5-i];
      tick(1);
      check_eq("bounce_run", outs(), 8'b0000);
    end
    left_raw = 1'b0;
    tick(10);
    check_eq("bounce_rest", outs(), 8'b0000);

    // 3. hazard toggle on/off while left held
    left_raw = 1'b1;
    tick(10);
    check_eq("haz_pre_left", outs(), 8'b1000);
    haz_btn_raw = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      if (i == 6) haz_btn_raw = 1'b0;
      if (i == 7) check_eq("haz_on_e7", outs(), 8'b1000);
      if (i == 8) check_eq("haz_on_gap", outs(), 8'b0000);
      if (i == 9) check_eq("haz_on", outs(), 8'b0010);
    end
    tick(10);
    check_eq("haz_release_noop", outs(), 8'b0010);
    haz_btn_raw = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      if (i == 6) haz_btn_raw = 1'b0;
      if (i == 7) check_eq("haz_off_e7", outs(), 8'b0010);
      if (i == 8) check_eq("haz_off_gap", outs(), 8'b0000);
      if (i == 9) check_eq("haz_off_left", outs(), 8'b1000);
    end

    // 4. both levers -> fault, then drop right
    right_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 6) check_eq("flt_e6", outs(), 8'b1000);
      if (i == 7) check_eq("flt_gap", outs(), 8'b0000);
      if (i == 8) check_eq("flt_on", outs(), 8'b0011);
    end
    tick(4);
    check_eq("flt_hold", outs(), 8'b0011);
    right_raw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 6) check_eq("flt_clr_e6", outs(), 8'b0011);
      if (i == 7) check_eq("flt_clr_gap", outs(), 8'b0000);
      if (i == 8) check_eq("flt_clr_left", outs(), 8'b1000);
    end

    // 5. simultaneous swap left -> right
    left_raw  = 1'b0;
    right_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 6) check_eq("swap_e6", outs(), 8'b1000);
      if (i == 7) check_eq("swap_gap", outs(), 8'b0000);
      if (i == 8) check_eq("swap_right", outs(), 8'b0100);
    end
    right_raw = 1'b0;
    tick(10);
    check_eq("swap_idle", outs(), 8'b0000);

`ifdef TBIRD_LANE_CHANGE_EN
    // 6. lane-change tap stretch, then tap cancelled by hazard
    left_raw = 1'b1;
    cnt      = 0;
    first    = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (i == 6) left_raw = 1'b0;
      if (left) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    check_eq("lane_len", 8'(cnt), 8'd12);
    check_eq("lane_rise", 8'(first), 8'd7);
    tick(5);
    check_eq("lane_idle", outs(), 8'b0000);
    left_raw = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick(1);
      if (i == 6) left_raw = 1'b0;
      if (i == 8) haz_btn_raw = 1'b1;
      if (i == 14) haz_btn_raw = 1'b0;
      if (i == 15) check_eq("lane_cancel_e15", outs(), 8'b1000);
      if (i == 16) check_eq("lane_cancel_gap", outs(), 8'b0000);
      if (i == 17) check_eq("lane_cancel_haz", outs(), 8'b0010);
    end
    haz_btn_raw = 1'b1;
    tick(6);
    haz_btn_raw = 1'b0;
    tick(10);
    check_eq("lane_haz_off", outs(), 8'b0000);
`endif

    // async reset mid-operation
    left_raw = 1'b1;
    tick(10);
    check_eq("arst_pre", outs(), 8'b1000);
    #3 rst_b = 1'b0;
    #1;
    check_eq("arst_immediate", outs(), 8'b0000);
    tick(2);
    check_eq("arst_hold", outs(), 8'b0000);
    rst_b = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
